// File: rtl/seq_mealy_det.sv
// Mealy sequence detector with loadable pattern and saturating match counter.
// Define SEQDET_OVERLAP_EN for overlapping detection (history-based fallback).
module seq_mealy_det #(
  parameter int                 W         = 2,
  parameter int                 DEPTH     = 4,
  parameter logic [W*DEPTH-1:0] RESET_PAT = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [W-1:0]             X,
  input  logic                     VALID,
  input  logic                     PAT_LOAD,
  input  logic [W*DEPTH-1:0]       PAT_DATA,
  output logic                     Z1,
  output logic                     Z2,
  output logic [$clog2(DEPTH)-1:0] PROG,
  output logic [7:0]               MATCH_CNT
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W*DEPTH-1:0] pat_q, pat_d;
  logic [PW-1:0]      prog_q, prog_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               z2_q, z2_d;
  logic               accept, hit, full;
  logic [PW-1:0]      fail;

  assign accept = VALID & ~PAT_LOAD;
  assign hit    = (X == pat_q[prog_q*W +: W]);
  assign full   = accept & (prog_q == LAST) & hit;

`ifdef SEQDET_OVERLAP_EN
  localparam int HW = W * (DEPTH - 1);

  logic [HW-1:0]      hist_q, hist_d;
  logic [W*DEPTH-1:0] win;
  logic               ok;

  assign win = {X, hist_q};

  // Longest prefix of PAT ending at X; k never exceeds prog_q+1,
  // so reset-cleared history slots cannot fake a match.
  always_comb begin
    fail = '0;
    ok   = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      ok = (k <= int'(prog_q) + 1);
      for (int j = 0; j < k; j++) begin
        if (win[(DEPTH-k+j)*W +: W] != pat_q[j*W +: W]) ok = 1'b0;
      end
      if (ok) fail = PW'(k);
    end
  end

  always_comb begin
    hist_d = hist_q;
    if (PAT_LOAD)    hist_d = '0;
    else if (VALID)  hist_d = win[W*DEPTH-1:W];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) hist_q <= '0;
    else     hist_q <= hist_d;
  end
`else
  always_comb begin
    fail = '0;
    if (!full && X == pat_q[W-1:0]) fail = PW'(1);
  end
`endif

  always_comb begin
    pat_d  = pat_q;
    prog_d = prog_q;
    cnt_d  = cnt_q;
    if (PAT_LOAD) begin
      pat_d  = PAT_DATA;
      prog_d = '0;
    end else if (VALID) begin
      if (hit && prog_q != LAST) prog_d = prog_q + PW'(1);
      else                       prog_d = fail;
      if (full && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
    z2_d = (prog_d != '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pat_q  <= RESET_PAT;
      prog_q <= '0;
      cnt_q  <= '0;
      z2_q   <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      prog_q <= prog_d;
      cnt_q  <= cnt_d;
      z2_q   <= z2_d;
    end
  end

  assign Z1        = full & ~RST;
  assign Z2        = z2_q;
  assign PROG      = prog_q;
  assign MATCH_CNT = cnt_q;

endmodule
